// File: rtl/l2_config_and_types_pkg.sv
// Shared L2 front-end types: per-port requests, the merged memory request,
// data-attribute FIFO entries and the arbiter state encoding.
package l2_config_and_types;

  localparam int L2_NUM_PORTS  = 2;
  localparam int L2_MAX_PORT_W = 3;
  localparam int L2_SUB_ID_W   = 2;
  localparam int L2_ID_W       = L2_MAX_PORT_W + L2_SUB_ID_W;
  localparam int L2_ADDR_W     = 32;
  localparam int L2_DATA_W     = 32;
  localparam int L2_BE_W       = 4;
  localparam int L2_BURST_W    = 5;
  localparam int L2_COUNT_W    = L2_BURST_W + 1;

  typedef struct packed {
    logic [L2_ADDR_W-1:0]   addr;
    logic [L2_BE_W-1:0]     be;
    logic                   rnw;
    logic                   is_amo;
    logic [L2_BURST_W-1:0]  amo_type_or_burst_size;
    logic [L2_SUB_ID_W-1:0] sub_id;
  } l2_request_t;

  typedef struct packed {
    logic [L2_ADDR_W-1:0]  addr;
    logic [L2_BE_W-1:0]    be;
    logic                  rnw;
    logic                  is_amo;
    logic [L2_BURST_W-1:0] amo_type_or_burst_size;
    logic [L2_ID_W-1:0]    id;
  } l2_mem_request_t;

  typedef struct packed {
    logic [L2_MAX_PORT_W-1:0] id;
    logic [L2_BURST_W-1:0]    burst_size;
    logic                     abort;
  } l2_data_attributes_t;

  typedef enum logic {
    ARB   = 1'b0,
    WDATA = 1'b1
  } l2_arb_state_t;

  // AMOs reuse the burst field for the operation code and always carry one word.
  function automatic logic [L2_BURST_W-1:0] burst_of(input l2_request_t r);
    return r.is_amo ? '0 : r.amo_type_or_burst_size;
  endfunction

endpackage

// File: rtl/l2_rr_priority_select.sv
// Round-robin priority search: first set request at or above ptr, wrapping.
module l2_rr_priority_select #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_vec,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_valid
);

  // N is a power of two, so the W-bit sum wraps exactly modulo N.
  always_comb begin
    logic [W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!any_valid && req_vec[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter merging per-port L2 requests into one registered memory
// request, then forwarding the owning port's write data for write bursts.
module l2_request_arbiter
  import l2_config_and_types::*;
#(
  parameter int NUM_PORTS = L2_NUM_PORTS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  l2_request_t [NUM_PORTS-1:0]         req,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0]                wr_valid,
  input  logic [NUM_PORTS-1:0][L2_DATA_W-1:0] wr_data,
  output logic [NUM_PORTS-1:0]                wr_ready,
  output logic                                mem_req_valid,
  output l2_mem_request_t                     mem_req,
  input  logic                                mem_req_ready,
  output logic                                mem_wr_valid,
  output logic [L2_DATA_W-1:0]                mem_wr_data,
  input  logic                                mem_wr_ready,
  output logic                                attr_push,
  output l2_data_attributes_t                 attr
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  l2_arb_state_t          state, state_next;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       owner;
  logic [L2_COUNT_W-1:0]  word_count;
  logic [NUM_PORTS-1:0]   grant_oh;
  logic [PTR_W-1:0]       grant_idx;
  logic                   any_valid;
  l2_request_t            grant_req;
  logic [L2_BURST_W-1:0]  grant_burst;
  logic                   accept_ok;
  logic                   req_xfer;
  logic                   wr_xfer;

  l2_rr_priority_select #(.N(NUM_PORTS)) u_rr (
    .req_vec   (req_valid),
    .ptr       (ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign grant_req   = req[grant_idx];
  assign grant_burst = burst_of(grant_req);
  assign accept_ok   = !mem_req_valid || mem_req_ready;
  assign req_xfer    = rst_n && (state == ARB) && any_valid && accept_ok;
  assign wr_xfer     = mem_wr_valid && mem_wr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ARB;
      ptr           <= '0;
      owner         <= '0;
      word_count    <= '0;
      mem_req_valid <= 1'b0;
      mem_req       <= '0;
    end else begin
      state <= state_next;
      // A fresh transfer overrides the consume, so back-to-back requests leave no bubble.
      if (req_xfer) begin
        mem_req_valid                  <= 1'b1;
        mem_req.addr                   <= grant_req.addr;
        mem_req.be                     <= grant_req.be;
        mem_req.rnw                    <= grant_req.rnw;
        mem_req.is_amo                 <= grant_req.is_amo;
        mem_req.amo_type_or_burst_size <= grant_req.amo_type_or_burst_size;
        mem_req.id                     <= L2_ID_W'({grant_idx, grant_req.sub_id});
        ptr                            <= grant_idx + PTR_W'(1);
      end else if (mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
      if (req_xfer && !grant_req.rnw) begin
        owner      <= grant_idx;
        word_count <= {1'b0, grant_burst} + L2_COUNT_W'(1);
      end else if (wr_xfer) begin
        word_count <= word_count - L2_COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (req_xfer && !grant_req.rnw) state_next = WDATA;
      WDATA:   if (wr_xfer && word_count == L2_COUNT_W'(1)) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    wr_ready     = '0;
    mem_wr_valid = 1'b0;
    mem_wr_data  = '0;
    attr_push    = 1'b0;
    attr.id         = L2_MAX_PORT_W'(grant_idx);
    attr.burst_size = grant_burst;
    attr.abort      = 1'b0;
    if (rst_n && state == ARB && accept_ok) begin
      req_ready = grant_oh;
      attr_push = req_xfer && !grant_req.rnw;
    end
    if (rst_n && state == WDATA) begin
      mem_wr_valid    = wr_valid[owner];
      mem_wr_data     = wr_data[owner];
      wr_ready[owner] = mem_wr_ready;
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: round-robin reads, write bursts,
// backpressure, AMO writes and reset in the middle of a burst.
module tb_l2_request_arbiter;
  import l2_config_and_types::*;

  localparam int NP = 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NP-1:0]               req_valid;
  l2_request_t [NP-1:0]        req;
  logic [NP-1:0]               req_ready;
  logic [NP-1:0]               wr_valid;
  logic [NP-1:0][L2_DATA_W-1:0] wr_data;
  logic [NP-1:0]               wr_ready;
  logic                        mem_req_valid;
  l2_mem_request_t             mem_req;
  logic                        mem_req_ready;
  logic                        mem_wr_valid;
  logic [L2_DATA_W-1:0]        mem_wr_data;
  logic                        mem_wr_ready;
  logic                        attr_push;
  l2_data_attributes_t         attr;

  int checks = 0;
  int errors = 0;

  l2_request_arbiter #(.NUM_PORTS(NP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req           (req),
    .req_ready     (req_ready),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req       (mem_req),
    .mem_req_ready (mem_req_ready),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ready  (mem_wr_ready),
    .attr_push     (attr_push),
    .attr          (attr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic rnw, input logic is_amo,
                               input logic [4:0] ats, input logic [1:0] sub_id, input logic [31:0] addr);
    req_valid[port]                  = valid;
    req[port].addr                   = addr;
    req[port].be                     = 4'hF;
    req[port].rnw                    = rnw;
    req[port].is_amo                 = is_amo;
    req[port].amo_type_or_burst_size = ats;
    req[port].sub_id                 = sub_id;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req           = '0;
    wr_valid      = '0;
    wr_data       = '0;
    mem_req_ready = 1'b1;
    mem_wr_ready  = 1'b1;

    // Reset: outputs quiet even with a request pending
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd1, 32'h100);
    tick();
    tick();
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_mem_req_valid", 64'(mem_req_valid), 64'h0);
    checkOutput("reset_attr_push", 64'(attr_push), 64'h0);
    checkOutput("reset_mem_wr_valid", 64'(mem_wr_valid), 64'h0);

    // Continuous reads from both ports alternate 0,1,0
    rst_n = 1'b1;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 5'd0, 2'd3, 32'h200);
    #1;
    checkOutput("rr_ready_first", 64'(req_ready), 64'h1);
    tick();
    checkOutput("rr_valid_0", 64'(mem_req_valid), 64'h1);
    checkOutput("rr_id_0", 64'(mem_req.id), 64'h1);
    checkOutput("rr_addr_0", 64'(mem_req.addr), 64'h100);
    checkOutput("rr_ready_second", 64'(req_ready), 64'h2);
    tick();
    checkOutput("rr_id_1", 64'(mem_req.id), 64'h7);
    checkOutput("rr_addr_1", 64'(mem_req.addr), 64'h200);
    checkOutput("rr_ready_third", 64'(req_ready), 64'h1);
    tick();
    checkOutput("rr_id_2", 64'(mem_req.id), 64'h1);
    req_valid = '0;
    #1;
    checkOutput("rr_ready_idle", 64'(req_ready), 64'h0);
    tick();
    checkOutput("rr_valid_cleared", 64'(mem_req_valid), 64'h0);

    // Backpressure: mem_req held stable, pending request moves on release
    mem_req_ready = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd2, 32'h300);
    #1;
    checkOutput("bp_ready_empty_reg", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd3, 32'h304);
    #1;
    checkOutput("bp_id_loaded", 64'(mem_req.id), 64'h2);
    checkOutput("bp_ready_blocked", 64'(req_ready), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_valid", 64'(mem_req_valid), 64'h1);
      checkOutput("bp_hold_addr", 64'(mem_req.addr), 64'h300);
      checkOutput("bp_hold_ready", 64'(req_ready), 64'h0);
    end
    mem_req_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    checkOutput("bp_reload_id", 64'(mem_req.id), 64'h3);
    checkOutput("bp_reload_addr", 64'(mem_req.addr), 64'h304);
    tick();
    checkOutput("bp_drained", 64'(mem_req_valid), 64'h0);

    // Port 1 write burst of 4 words; port 0 read and stray write data must wait
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 5'd3, 2'd2, 32'h400);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 32'h500);
    wr_valid   = 2'b11;
    wr_data[0] = 32'h0000_BAD0;
    wr_data[1] = 32'hD000_0000;
    #1;
    checkOutput("wr_grant_ready", 64'(req_ready), 64'h2);
    checkOutput("wr_attr_push", 64'(attr_push), 64'h1);
    checkOutput("wr_attr", 64'(attr), 64'({3'd1, 5'd3, 1'b0}));
    checkOutput("wr_arb_wr_ready", 64'(wr_ready), 64'h0);
    checkOutput("wr_arb_mem_wr_valid", 64'(mem_wr_valid), 64'h0);
    tick();
    req_valid[1] = 1'b0;
    #1;
    checkOutput("wr_mem_id", 64'(mem_req.id), 64'h6);
    checkOutput("wr_mem_rnw", 64'(mem_req.rnw), 64'h0);
    checkOutput("wr_attr_push_once", 64'(attr_push), 64'h0);
    checkOutput("wr_req_ready_blocked", 64'(req_ready), 64'h0);
    checkOutput("wr_word0_valid", 64'(mem_wr_valid), 64'h1);
    checkOutput("wr_word0_data", 64'(mem_wr_data), 64'hD000_0000);
    checkOutput("wr_owner_only_ready", 64'(wr_ready), 64'h2);
    tick();
    wr_data[1] = 32'hD000_0001;
    #1;
    checkOutput("wr_word1_data", 64'(mem_wr_data), 64'hD000_0001);
    tick();
    wr_data[1]   = 32'hD000_0002;
    mem_wr_ready = 1'b0;
    #1;
    checkOutput("wr_stall_ready", 64'(wr_ready), 64'h0);
    checkOutput("wr_stall_valid", 64'(mem_wr_valid), 64'h1);
    tick();
    mem_wr_ready = 1'b1;
    #1;
    checkOutput("wr_word2_data", 64'(mem_wr_data), 64'hD000_0002);
    checkOutput("wr_word2_ready", 64'(wr_ready), 64'h2);
    tick();
    wr_data[1] = 32'hD000_0003;
    #1;
    checkOutput("wr_word3_data", 64'(mem_wr_data), 64'hD000_0003);
    checkOutput("wr_word3_req_blocked", 64'(req_ready), 64'h0);
    tick();
    checkOutput("wr_done_mem_wr_valid", 64'(mem_wr_valid), 64'h0);
    checkOutput("wr_done_wr_ready", 64'(wr_ready), 64'h0);
    checkOutput("wr_done_port0_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    wr_valid  = '0;
    checkOutput("wr_after_id", 64'(mem_req.id), 64'h0);
    checkOutput("wr_after_addr", 64'(mem_req.addr), 64'h500);
    tick();
    checkOutput("wr_after_drained", 64'(mem_req_valid), 64'h0);

    // AMO write carries exactly one data word
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 5'h0C, 2'd1, 32'h600);
    wr_valid[0] = 1'b1;
    wr_data[0]  = 32'h0000_A0A0;
    #1;
    checkOutput("amo_ready", 64'(req_ready), 64'h1);
    checkOutput("amo_attr_push", 64'(attr_push), 64'h1);
    checkOutput("amo_attr", 64'(attr), 64'h0);
    tick();
    req_valid = '0;
    #1;
    checkOutput("amo_mem_id", 64'(mem_req.id), 64'h1);
    checkOutput("amo_mem_type", 64'(mem_req.amo_type_or_burst_size), 64'h0C);
    checkOutput("amo_word_valid", 64'(mem_wr_valid), 64'h1);
    checkOutput("amo_word_data", 64'(mem_wr_data), 64'hA0A0);
    checkOutput("amo_word_ready", 64'(wr_ready), 64'h1);
    tick();
    checkOutput("amo_single_word", 64'(mem_wr_valid), 64'h0);
    checkOutput("amo_single_ready", 64'(wr_ready), 64'h0);

    // Reset after 2 of 4 burst words abandons the burst and rewinds the pointer
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 5'd3, 2'd0, 32'h700);
    wr_data[0] = 32'h0000_00E0;
    #1;
    checkOutput("rst_burst_ready", 64'(req_ready), 64'h1);
    checkOutput("rst_burst_push", 64'(attr_push), 64'h1);
    tick();
    req_valid = '0;
    #1;
    checkOutput("rst_burst_word0", 64'(mem_wr_valid), 64'h1);
    tick();
    checkOutput("rst_burst_word1", 64'(mem_wr_data), 64'hE0);
    tick();
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd1, 32'h800);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 32'h900);
    #1;
    checkOutput("rst_cycle_mem_wr_valid", 64'(mem_wr_valid), 64'h0);
    checkOutput("rst_cycle_wr_ready", 64'(wr_ready), 64'h0);
    checkOutput("rst_cycle_req_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_cycle_attr_push", 64'(attr_push), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
    checkOutput("post_rst_arb_state", 64'(mem_wr_valid), 64'h0);
    checkOutput("post_rst_ptr_zero", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    wr_valid  = '0;
    checkOutput("post_rst_id", 64'(mem_req.id), 64'h1);
    checkOutput("post_rst_addr", 64'(mem_req.addr), 64'h800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
